writeback_unit: RTL and testbench

Writeback stage for the RV32IMF core. It merges results from the fixed-latency execute/memory pipe and the variable-latency multiply/divide unit onto the register file's single write port. It formats load data, arbitrates the two sources, and keeps a per-register busy scoreboard so decode can stall on hazards against outstanding multiply/divide results.

---
 rtl/writeback_if.sv | 45 ++++
 rtl/writeback_unit.sv | 122 ++++++++++++
 tb/tb_writeback_unit.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_if.sv
// Bundle of writeback-stage signals: pipe result, mul/div result, decode hazard query,
// and the register file write port.
interface writeback_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            pipe_valid;
    logic            pipe_reg_write;
    logic            pipe_mem_to_reg;
    logic [4:0]      pipe_rd;
    logic [XLEN-1:0] pipe_alu_result;
    logic [XLEN-1:0] pipe_mem_rdata;
    logic [2:0]      pipe_funct3;
    logic            pipe_stall;

    logic            mul_valid;
    logic [4:0]      mul_rd;
    logic [XLEN-1:0] mul_result;
    logic            mul_ready;
    logic            mul_issue;
    logic [4:0]      mul_issue_rd;

    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            hazard;

    logic [4:0]      write_reg;
    logic [XLEN-1:0] write_data;
    logic            reg_write;
    logic            load_misaligned;

    modport master (
        output pipe_valid, pipe_reg_write, pipe_mem_to_reg, pipe_rd, pipe_alu_result,
               pipe_mem_rdata, pipe_funct3, mul_valid, mul_rd, mul_result, mul_issue,
               mul_issue_rd, rs1, rs2, rd,
        input  pipe_stall, mul_ready, hazard, write_reg, write_data, reg_write, load_misaligned
    );

    modport slave (
        input  pipe_valid, pipe_reg_write, pipe_mem_to_reg, pipe_rd, pipe_alu_result,
               pipe_mem_rdata, pipe_funct3, mul_valid, mul_rd, mul_result, mul_issue,
               mul_issue_rd, rs1, rs2, rd,
        output pipe_stall, mul_ready, hazard, write_reg, write_data, reg_write, load_misaligned
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: formats loads, arbitrates pipe vs. mul/div onto the single register
// file write port with starvation protection, and tracks outstanding mul/div destinations.
module writeback_unit #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic        clk,
    input logic        rst,
    writeback_if.slave wb
);
    logic [1:0]      lane;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_data;
    logic            fmt_misaligned;
    logic            load_mis;
    logic            pipe_wants;
    logic            pipe_req;
    logic            mul_fire;
    logic            mul_req;

    logic [4:0]      write_reg_q, write_reg_d;
    logic [XLEN-1:0] write_data_q, write_data_d;
    logic            reg_write_q, reg_write_d;
    logic            from_mul_q, from_mul_d;
    logic            load_mis_q, load_mis_d;
    logic            force_grant_q, force_grant_d;
    logic [3:0]      starve_q, starve_d;
    logic [31:0]     busy_q, busy_d;

    assign lane     = wb.pipe_alu_result[1:0];
    assign byte_sel = wb.pipe_mem_rdata[{lane, 3'b000} +: 8];
    assign half_sel = wb.pipe_mem_rdata[{lane[1], 4'b0000} +: 16];

    always_comb begin
        load_data      = wb.pipe_mem_rdata;
        fmt_misaligned = 1'b0;
        case (wb.pipe_funct3)
            3'b000: load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b100: load_data = {{(XLEN-8){1'b0}}, byte_sel};
            3'b001: begin
                load_data      = {{(XLEN-16){half_sel[15]}}, half_sel};
                fmt_misaligned = lane[0];
            end
            3'b101: begin
                load_data      = {{(XLEN-16){1'b0}}, half_sel};
                fmt_misaligned = lane[0];
            end
            default: fmt_misaligned = (lane != 2'b00);
        endcase
    end

    assign load_mis   = wb.pipe_mem_to_reg & fmt_misaligned;
    assign pipe_wants = wb.pipe_valid & wb.pipe_reg_write & (wb.pipe_rd != 5'd0);
    // The forced-grant cycle doubles as the pipe stall, so the pipe cannot write then.
    assign pipe_req   = pipe_wants & ~load_mis & ~force_grant_q;
    assign mul_fire   = wb.mul_valid & wb.mul_ready;
    assign mul_req    = mul_fire & (wb.mul_rd != 5'd0);

    assign wb.mul_ready       = force_grant_q | ~pipe_wants;
    assign wb.pipe_stall      = force_grant_q;
    assign wb.hazard          = busy_q[wb.rs1] | busy_q[wb.rs2] | busy_q[wb.rd];
    assign wb.write_reg       = write_reg_q;
    assign wb.write_data      = write_data_q;
    assign wb.reg_write       = reg_write_q;
    assign wb.load_misaligned = load_mis_q;

    always_comb begin
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        reg_write_d  = pipe_req | mul_req;
        from_mul_d   = ~pipe_req & mul_req;
        load_mis_d   = wb.pipe_valid & ~force_grant_q & load_mis;
        if (pipe_req) begin
            write_reg_d  = wb.pipe_rd;
            write_data_d = wb.pipe_mem_to_reg ? load_data : wb.pipe_alu_result;
        end else if (mul_req) begin
            write_reg_d  = wb.mul_rd;
            write_data_d = wb.mul_result;
        end

        starve_d = starve_q;
        if (!wb.mul_valid || mul_fire) begin
            starve_d = 4'd0;
        end else if (starve_q < 4'(STARVE_LIMIT)) begin
            starve_d = starve_q + 4'd1;
        end
        force_grant_d = (starve_d == 4'(STARVE_LIMIT));

        // Clear on the mul write's output cycle; a same-cycle issue re-sets the bit.
        busy_d = busy_q;
        if (reg_write_q && from_mul_q) begin
            busy_d[write_reg_q] = 1'b0;
        end
        if (wb.mul_issue) begin
            busy_d[wb.mul_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_reg_q   <= '0;
            write_data_q  <= '0;
            reg_write_q   <= 1'b0;
            from_mul_q    <= 1'b0;
            load_mis_q    <= 1'b0;
            force_grant_q <= 1'b0;
            starve_q      <= '0;
            busy_q        <= '0;
        end else begin
            write_reg_q   <= write_reg_d;
            write_data_q  <= write_data_d;
            reg_write_q   <= reg_write_d;
            from_mul_q    <= from_mul_d;
            load_mis_q    <= load_mis_d;
            force_grant_q <= force_grant_d;
            starve_q      <= starve_d;
            busy_q        <= busy_d;
        end
    end
endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed stimulus pushes expected writes, a negedge
// monitor pops them whenever the register file port (or misalignment flag) is active.
module tb_writeback_unit;
    typedef struct {
        logic        mis;
        logic [4:0]  rg;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];

    writeback_if #(.XLEN(32)) bus ();

    writeback_unit #(.XLEN(32), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, got, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] rg, input logic [31:0] data);
        exp_t e;
        e.mis = 1'b0; e.rg = rg; e.data = data;
        expq.push_back(e);
    endtask

    task automatic expect_mis();
        exp_t e;
        e.mis = 1'b1; e.rg = 5'd0; e.data = 32'd0;
        expq.push_back(e);
    endtask

    // Monitor: any active output must match the oldest expected event.
    always @(negedge clk) begin
        if (bus.reg_write === 1'b1 || bus.load_misaligned === 1'b1) begin
            exp_t e;
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: reg_write=%b reg=%0d data=0x%08h mis=%b",
                         bus.reg_write, bus.write_reg, bus.write_data, bus.load_misaligned);
            end else begin
                e = expq.pop_front();
                if (e.mis) begin
                    if (bus.load_misaligned !== 1'b1 || bus.reg_write !== 1'b0) begin
                        errors++;
                        $display("FAIL misaligned_event: got mis=%b reg_write=%b, want mis=1 reg_write=0",
                                 bus.load_misaligned, bus.reg_write);
                    end
                end else if (bus.reg_write !== 1'b1 || bus.load_misaligned !== 1'b0 ||
                             bus.write_reg !== e.rg || bus.write_data !== e.data) begin
                    errors++;
                    $display("FAIL write_event: got we=%b mis=%b x%0d=0x%08h, want we=1 mis=0 x%0d=0x%08h",
                             bus.reg_write, bus.load_misaligned, bus.write_reg, bus.write_data,
                             e.rg, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic pipe_off();
        bus.pipe_valid = 1'b0; bus.pipe_reg_write = 1'b0; bus.pipe_mem_to_reg = 1'b0;
        bus.pipe_rd = 5'd0; bus.pipe_alu_result = 32'd0; bus.pipe_mem_rdata = 32'd0;
        bus.pipe_funct3 = 3'b010;
    endtask

    task automatic pipe_alu(input logic [4:0] rd, input logic [31:0] val);
        bus.pipe_valid = 1'b1; bus.pipe_reg_write = 1'b1; bus.pipe_mem_to_reg = 1'b0;
        bus.pipe_rd = rd; bus.pipe_alu_result = val;
    endtask

    task automatic mul_set(input logic v, input logic [4:0] rd, input logic [31:0] res);
        bus.mul_valid = v; bus.mul_rd = rd; bus.mul_result = res;
    endtask

    logic [31:0] ld_addr [6] = '{32'h3, 32'h2, 32'h0, 32'h2, 32'h0, 32'h1};
    logic [2:0]  ld_f3   [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b001};
    logic [31:0] ld_exp  [6] = '{32'hFFFFFF80, 32'h00000070, 32'hFFFFF0A1, 32'h00008070,
                                 32'h8070F0A1, 32'h0};
    logic        ld_mis  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        pipe_off();
        mul_set(1'b0, 5'd0, 32'd0);
        bus.mul_issue = 1'b0; bus.mul_issue_rd = 5'd0;
        bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.rd = 5'd0;
        tick(); tick();
        rst = 1'b0;
        settle();
        check("reset_reg_write", 32'(bus.reg_write), 32'd0);
        check("reset_write_reg", 32'(bus.write_reg), 32'd0);
        check("reset_write_data", bus.write_data, 32'd0);
        check("reset_load_mis", 32'(bus.load_misaligned), 32'd0);
        check("reset_pipe_stall", 32'(bus.pipe_stall), 32'd0);
        check("reset_hazard", 32'(bus.hazard), 32'd0);
        check("idle_mul_ready", 32'(bus.mul_ready), 32'd1);

        // ALU write, then rd=0 (no write)
        tick();
        pipe_alu(5'd5, 32'hDEADBEEF); expect_wr(5'd5, 32'hDEADBEEF);
        tick();
        pipe_alu(5'd0, 32'h12345678);
        tick();
        pipe_off();
        tick();

        // Load formatting and misalignment
        for (int i = 0; i < 6; i++) begin
            bus.pipe_valid = 1'b1; bus.pipe_reg_write = 1'b1; bus.pipe_mem_to_reg = 1'b1;
            bus.pipe_rd = 5'(10 + i); bus.pipe_alu_result = ld_addr[i];
            bus.pipe_mem_rdata = 32'h8070F0A1; bus.pipe_funct3 = ld_f3[i];
            if (ld_mis[i]) expect_mis();
            else expect_wr(5'(10 + i), ld_exp[i]);
            tick();
        end
        pipe_off();
        tick(); tick();

        // Collision: pipe wins, mul goes next idle cycle
        pipe_alu(5'd3, 32'h33); mul_set(1'b1, 5'd7, 32'h77);
        settle();
        check("collision_mul_ready", 32'(bus.mul_ready), 32'd0);
        expect_wr(5'd3, 32'h33);
        tick();
        pipe_off();
        settle();
        check("after_collision_mul_ready", 32'(bus.mul_ready), 32'd1);
        expect_wr(5'd7, 32'h77);
        tick();
        mul_set(1'b0, 5'd0, 32'd0);
        tick();

        // Starvation: 4 blocked cycles, then forced grant with pipe held
        mul_set(1'b1, 5'd8, 32'h88);
        for (int i = 0; i < 4; i++) begin
            pipe_alu(5'(20 + i), 32'hA000 + 32'(i));
            settle();
            check("starve_no_stall", 32'(bus.pipe_stall), 32'd0);
            expect_wr(5'(20 + i), 32'hA000 + 32'(i));
            tick();
        end
        pipe_alu(5'd24, 32'hA004);
        settle();
        check("starve_stall", 32'(bus.pipe_stall), 32'd1);
        check("starve_mul_ready", 32'(bus.mul_ready), 32'd1);
        expect_wr(5'd8, 32'h88);
        tick();
        mul_set(1'b0, 5'd0, 32'd0);
        settle();
        check("stall_released", 32'(bus.pipe_stall), 32'd0);
        expect_wr(5'd24, 32'hA004);
        tick();
        pipe_off();
        tick();

        // Scoreboard: hazard through the mul write's output cycle
        bus.mul_issue = 1'b1; bus.mul_issue_rd = 5'd9;
        tick();
        bus.mul_issue = 1'b0; bus.rs2 = 5'd9;
        settle();
        check("hazard_after_issue", 32'(bus.hazard), 32'd1);
        tick();
        mul_set(1'b1, 5'd9, 32'h99); expect_wr(5'd9, 32'h99);
        settle();
        check("hazard_mul_accept", 32'(bus.hazard), 32'd1);
        tick();
        mul_set(1'b0, 5'd0, 32'd0);
        settle();
        check("hazard_write_cycle", 32'(bus.hazard), 32'd1);
        tick();
        check("hazard_cleared", 32'(bus.hazard), 32'd0);
        bus.rs2 = 5'd0; bus.rs1 = 5'd9;

        // Set and clear of x9 in the same cycle: set wins
        bus.mul_issue = 1'b1; bus.mul_issue_rd = 5'd9;
        tick();
        bus.mul_issue = 1'b0;
        mul_set(1'b1, 5'd9, 32'h999); expect_wr(5'd9, 32'h999);
        tick();
        mul_set(1'b0, 5'd0, 32'd0);
        bus.mul_issue = 1'b1; bus.mul_issue_rd = 5'd9;
        tick();
        bus.mul_issue = 1'b0;
        settle();
        check("set_wins_hazard", 32'(bus.hazard), 32'd1);
        tick();
        check("set_wins_hazard_later", 32'(bus.hazard), 32'd1);
        mul_set(1'b1, 5'd9, 32'h9999); expect_wr(5'd9, 32'h9999);
        tick();
        mul_set(1'b0, 5'd0, 32'd0);
        tick(); tick();
        check("x9_free", 32'(bus.hazard), 32'd0);
        bus.rs1 = 5'd0;

        // Reset mid-operation: counter at 3, busy[4] set, pipe write in flight
        bus.mul_issue = 1'b1; bus.mul_issue_rd = 5'd4;
        tick();
        bus.mul_issue = 1'b0;
        mul_set(1'b1, 5'd4, 32'h44);
        for (int i = 0; i < 3; i++) begin
            pipe_alu(5'(25 + i), 32'hB000 + 32'(i));
            expect_wr(5'(25 + i), 32'hB000 + 32'(i));
            tick();
        end
        pipe_alu(5'd28, 32'hDEAD0028);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.rd = 5'd4;
        settle();
        check("rst_mid_reg_write", 32'(bus.reg_write), 32'd0);
        check("rst_mid_write_reg", 32'(bus.write_reg), 32'd0);
        check("rst_mid_write_data", bus.write_data, 32'd0);
        check("rst_mid_stall", 32'(bus.pipe_stall), 32'd0);
        check("rst_mid_busy", 32'(bus.hazard), 32'd0);
        bus.rd = 5'd0;
        // Counter restarted from 0: four more blocked cycles before the forced grant
        for (int i = 0; i < 4; i++) begin
            pipe_alu(5'(28 + i), 32'hC000 + 32'(i));
            settle();
            check("rst_counter_no_stall", 32'(bus.pipe_stall), 32'd0);
            expect_wr(5'(28 + i), 32'hC000 + 32'(i));
            tick();
        end
        pipe_alu(5'd1, 32'hC004);
        settle();
        check("rst_counter_stall", 32'(bus.pipe_stall), 32'd1);
        expect_wr(5'd4, 32'h44);
        tick();
        mul_set(1'b0, 5'd0, 32'd0);
        expect_wr(5'd1, 32'hC004);
        tick();
        pipe_off();
        tick(); tick(); tick();

        check("queue_drained", 32'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
